bit_serializer: RTL

- Upstream feeder for the serial sequence detector.
- Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on serial_bit, MSB first, with bit_valid qualifying each bit.
- A one-word holding buffer lets consecutive words stream with no idle gap, so the detector sees patterns that span word boundaries.

---
 rtl/bit_serializer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial feeder for the serial sequence detector.
// Words arrive over a valid/ready handshake and leave one bit per clock on
// serial_bit, qualified by bit_valid. A one-word holding buffer lets
// consecutive words stream with no idle cycle between them.
//
// Optional build macro SER_LSB_FIRST_EN: when defined, words are shifted out
// LSB first; otherwise MSB first. Handshake, timing and counts are identical.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | nothing shifting; serial_bit parked at IDLE_BIT
// S_SHIFT | shift_reg driving serial_bit; bit_cnt bits remain after this one
module bit_serializer #(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             serial_bit,
    output logic             bit_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_shift;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [WIDTH-1:0]   r_buf;
    logic               r_buf_full;

    state_t             w_state_nxt;
    logic [WIDTH-1:0]   w_shift_nxt;
    logic [CNT_W-1:0]   w_bit_cnt_nxt;
    logic [WIDTH-1:0]   w_buf_nxt;
    logic               w_buf_full_nxt;

    logic               w_accept;
    logic               w_last_bit;
    logic [WIDTH-1:0]   w_shifted;
    logic               w_out_bit;

    // Bit ordering: the only place the optional LSB-first mode differs.
`ifdef SER_LSB_FIRST_EN
    assign w_shifted = r_shift >> 1;
    assign w_out_bit = r_shift[0];
`else
    assign w_shifted = r_shift << 1;
    assign w_out_bit = r_shift[WIDTH-1];
`endif

    // Ready is held low during reset so no word can slip in as state clears.
    assign data_ready = !r_buf_full && !reset;
    assign w_accept   = data_valid && data_ready;
    assign w_last_bit = (r_bit_cnt == '0);

    assign serial_bit = (r_state == S_SHIFT) ? w_out_bit : IDLE_BIT;
    assign bit_valid  = (r_state == S_SHIFT);
    assign word_done  = (r_state == S_SHIFT) && w_last_bit;
    assign busy       = (r_state == S_SHIFT) || r_buf_full;

    // Next-state and datapath update; the buffer is only filled mid-word,
    // so a word arriving while idle or on the last bit loads the shifter directly.
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_buf_nxt      = r_buf;
        w_buf_full_nxt = r_buf_full;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_shift_nxt   = data_in;
                    w_bit_cnt_nxt = CNT_LAST;
                    w_state_nxt   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (!w_last_bit) begin
                    w_shift_nxt   = w_shifted;
                    w_bit_cnt_nxt = r_bit_cnt - 1'b1;
                    if (w_accept) begin
                        w_buf_nxt      = data_in;
                        w_buf_full_nxt = 1'b1;
                    end
                end else if (r_buf_full) begin
                    w_shift_nxt    = r_buf;
                    w_buf_full_nxt = 1'b0;
                    w_bit_cnt_nxt  = CNT_LAST;
                end else if (w_accept) begin
                    w_shift_nxt   = data_in;
                    w_bit_cnt_nxt = CNT_LAST;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register; reset discards both the shifting and the buffered word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_buf      <= '0;
            r_buf_full <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_buf      <= w_buf_nxt;
            r_buf_full <= w_buf_full_nxt;
        end
    end

endmodule
